core_mem_responder: RTL and testbench
=====================================

# core_mem_responder

Simulation and formal memory responder: the slave end of the core's req/gnt memory interface, one instance each for imem and dmem. Holds a strobe-writable word array and answers each held request with a one-cycle grant carrying read data or an error. An LFSR-driven stall and a programmable error window exercise back-pressure and fault paths. A sticky flag records initiator protocol violations.

## Interface
- `MEM_ADDR_W`, 64: request address width.
- `MEM_DATA_W`, 64: data width. Strobe width is `MEM_DATA_W/8`.
- `BASE_ADDR`, 64'h0000_0000_0000_0000: first byte address of the array. Must be aligned to the array size.
- `DEPTH`, 1024: array size in words. Must be a power of two.
- `ERR_BASE`, 64'h0000_0000_0000_1000: base of the error window.
- `ERR_MASK`, 64'hFFFF_FFFF_FFFF_F000: mask applied to `mem_addr` before comparing against `ERR_BASE`.
- `STALL_MAX`, 3: maximum stall in cycles. Legal values are 0, 1, 3, 7 and 15.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be non-zero.
- `g_clk` in 1: clock.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `stall_en` in 1: 0 forces every stall to zero.
- `mem_req` in 1: request valid.
- `mem_addr` in MEM_ADDR_W: byte address. Bits [2:0] are ignored.
- `mem_wen` in 1: write enable.
- `mem_strb` in MEM_DATA_W/8: byte write strobe.
- `mem_wdata` in MEM_DATA_W: write data.
- `mem_gnt` out 1: response valid, one-cycle pulse.
- `mem_err` out 1: response error. Valid only while `mem_gnt` is high.
- `mem_rdata` out MEM_DATA_W: read data. Valid only while `mem_gnt` is high.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- Initiator rule: once `mem_req` rises, `mem_req`, `mem_addr`, `mem_wen`, `mem_strb` and `mem_wdata` hold stable until the cycle `mem_gnt` is high.
- FSM states:
  - IDLE:
    - On `mem_req`: capture the request, load `stall_cnt`, go to WAIT.
  - WAIT:
    - If `mem_req` drops or any captured field changes: set `proto_err`, go to IDLE with no grant.
    - Else if `stall_cnt` == 0: go to RESP.
    - Else decrement `stall_cnt`.
  - RESP:
    - `mem_gnt` = 1 for exactly one cycle, then go to IDLE.
    - A request that is still high in the cycle after RESP is treated as a new request.
- Stall load value: `lfsr[3:0] & STALL_MAX` when `stall_en` = 1, else 0.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Steps every cycle out of reset, independent of traffic.
- Address decode, on the captured address:
  - in_range = ((addr & ~(DEPTH*8-1)) == BASE_ADDR).
  - in_err = ((addr & ERR_MASK) == ERR_BASE).
  - index = addr[log2(DEPTH)+2:3].
- Error response: `mem_err` = in_err | ~in_range. `in_err` takes priority even when the address is in range.
- On error:
  - `mem_rdata` = 0.
  - No array write.
- Write (`wen` = 1, no error):
  - At the RESP clock edge, each byte i with `strb[i]` set takes `wdata[8i+7:8i]`.
  - `mem_rdata` = 0.
- Read (`wen` = 0, no error): `mem_rdata` = the array word, registered at RESP entry.
- `proto_err` clears only on reset.
- The array is not reset. Its contents are X until written or preloaded through `$readmemh` by the bench.

## Timing
- Reset values:
  - `mem_gnt` = 0, `mem_err` = 0, `mem_rdata` = 0, `proto_err` = 0.
  - FSM = IDLE, `lfsr` = `LFSR_SEED`, `stall_cnt` = 0.
- Reset asserted mid-transaction: the FSM returns to IDLE and any pending write is discarded.
- Latency from `mem_req` rising (cycle 0):
  - Capture at the cycle-0 edge.
  - `mem_gnt` high in cycle 2+stall, where stall is 0..STALL_MAX.
  - Minimum latency is 2 cycles; maximum is 2+STALL_MAX.
- Back-to-back throughput is one transaction per 3+stall cycles.
- `mem_err` and `mem_rdata` are registered and driven only in the RESP cycle; they are 0 in all other cycles.
- A protocol violation in WAIT sets `proto_err` on the following edge.

## Structure
- Package `core_mem_responder_pkg`: state enum (IDLE, WAIT, RESP) and LFSR tap constant.
- Widths come from the core's common parameter set.
- One sub-module, `core_lfsr16`:
  - Ports: `g_clk`, `g_resetn`, `seed`, `q[15:0]`.
  - Async reset to `seed`.
- Two instances are used in the testbench top, one for imem and one for dmem. The dmem instance takes `ERR_BASE` = MMIO base.

## Test plan
- Reset, `stall_en`=0: write addr 0x10, strb 0xFF, wdata 0x1122334455667788 -> `mem_gnt` in cycle 2 with `mem_err`=0. Then read 0x10 -> `mem_rdata`=0x1122334455667788.
- Partial strobe: write 0x10 with strb 0x0F, wdata 0xFFFFFFFFFFFFFFFF over the previous value -> read returns 0x11223344FFFFFFFF.
- Error window: read 0x1008 -> `mem_gnt` with `mem_err`=1 and `mem_rdata`=0. A write to 0x1008 leaves the array unchanged. An out-of-range address (`DEPTH`*8) also returns `mem_err`=1.
- Stalls: `stall_en`=1, `STALL_MAX`=3, seed 0xACE1, 1000 random requests -> every grant latency is in 2..5, and all four stall values occur.
- Protocol violation: drop `mem_req` in WAIT, or change `mem_addr` mid-wait -> no grant for that request and `proto_err`=1 until reset.
- Async reset pulse during WAIT of a write to 0x20 -> all outputs are 0 immediately, and a later read of 0x20 returns the old value.

Source files
------------

// File: rtl/core_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_responder_pkg
// Description : Shared types and constants for the memory responder slice.
// Revision    : 1.0 - initial release
// ============================================================================
package core_mem_responder_pkg;

    localparam int unsigned CORE_ADDR_W    = 64;
    localparam int unsigned CORE_DATA_W    = 64;
    localparam logic [63:0] CORE_MMIO_BASE = 64'h0000_0000_1000_0000;

    // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAP_MASK  = 16'h002D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/core_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : core_lfsr16
// Description : Free-running 16-bit Fibonacci LFSR, async reset to seed.
// Revision    : 1.0 - initial release
// ============================================================================
module core_lfsr16
    import core_mem_responder_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {^(lfsr_q & LFSR_TAP_MASK), lfsr_q[15:1]};
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/core_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_responder
// Description : req/gnt memory slave with random stalls, error window and
//               sticky initiator protocol-violation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_responder
    import core_mem_responder_pkg::*;
#(
    parameter int unsigned           MEM_ADDR_W = CORE_ADDR_W,
    parameter int unsigned           MEM_DATA_W = CORE_DATA_W,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR  = 64'h0000_0000_0000_0000,
    parameter int unsigned           DEPTH      = 1024,
    parameter logic [MEM_ADDR_W-1:0] ERR_BASE   = 64'h0000_0000_0000_1000,
    parameter logic [MEM_ADDR_W-1:0] ERR_MASK   = 64'hFFFF_FFFF_FFFF_F000,
    parameter int unsigned           STALL_MAX  = 3,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
    input  logic                    g_clk,
    input  logic                    g_resetn,
    input  logic                    stall_en,
    input  logic                    mem_req,
    input  logic [MEM_ADDR_W-1:0]   mem_addr,
    input  logic                    mem_wen,
    input  logic [MEM_DATA_W/8-1:0] mem_strb,
    input  logic [MEM_DATA_W-1:0]   mem_wdata,
    output logic                    mem_gnt,
    output logic                    mem_err,
    output logic [MEM_DATA_W-1:0]   mem_rdata,
    output logic                    proto_err
);

    localparam int unsigned           STRB_W    = MEM_DATA_W / 8;
    localparam int unsigned           IDX_W     = $clog2(DEPTH);
    localparam logic [MEM_ADDR_W-1:0] ARR_MASK  = ~(MEM_ADDR_W'(DEPTH * 8 - 1));
    localparam logic [3:0]            STALL_MSK = 4'(STALL_MAX);

    state_e                  state_q, state_d;
    logic [3:0]              stall_cnt_q, stall_cnt_d;
    logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [MEM_DATA_W-1:0]   wdata_q, wdata_d;
    logic                    gnt_q, gnt_d;
    logic                    err_q, err_d;
    logic [MEM_DATA_W-1:0]   rdata_q, rdata_d;
    logic                    proto_err_q, proto_err_d;

    logic [MEM_DATA_W-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [IDX_W-1:0]        idx;
    logic                    acc_err;
    logic                    viol;
    logic [15:0]             lfsr;
    logic                    unused_lfsr_hi;

    core_lfsr16 u_lfsr (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .seed     (LFSR_SEED),
        .q        (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:4];

    // Error window wins over the in-range check
    assign idx     = addr_q[IDX_W+2:3];
    assign acc_err = ((addr_q & ERR_MASK) == ERR_BASE) || ((addr_q & ARR_MASK) != BASE_ADDR);
    assign viol    = !mem_req || (mem_addr != addr_q) || (mem_wen != wen_q)
                     || (mem_strb != strb_q) || (mem_wdata != wdata_q);

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        gnt_d       = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
        proto_err_d = proto_err_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    addr_d      = mem_addr;
                    wen_d       = mem_wen;
                    strb_d      = mem_strb;
                    wdata_d     = mem_wdata;
                    stall_cnt_d = stall_en ? (lfsr[3:0] & STALL_MSK) : 4'd0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (viol) begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (stall_cnt_q == 4'd0) begin
                    state_d = RESP;
                    gnt_d   = 1'b1;
                    err_d   = acc_err;
                    rdata_d = (acc_err || wen_q) ? '0 : mem_q[idx];
                    mem_we  = wen_q && !acc_err;
                end else begin
                    stall_cnt_d = stall_cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= IDLE;
            stall_cnt_q <= 4'd0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            strb_q      <= '0;
            wdata_q     <= '0;
            gnt_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            strb_q      <= strb_d;
            wdata_q     <= wdata_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Array has no reset; mem_we is already gated by the async-reset FSM state
    always_ff @(posedge g_clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (strb_q[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign mem_gnt   = gnt_q;
    assign mem_err   = err_q;
    assign mem_rdata = rdata_q;
    assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem_responder
// Description : Directed self-checking bench for core_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_responder;

    logic        g_clk;
    logic        g_resetn;
    logic        stall_en;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [7:0]  mem_strb;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_err;
    logic [63:0] mem_rdata;
    logic        proto_err;

    int vec  = 0;
    int miss = 0;

    int          lat;
    logic        err;
    logic [63:0] rd;
    int          hist [0:7];
    logic        saw_gnt;

    core_mem_responder #(
        .STALL_MAX (3),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .stall_en  (stall_en),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_strb  (mem_strb),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_err   (mem_err),
        .mem_rdata (mem_rdata),
        .proto_err (proto_err)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and hold it until the grant; lat = -1 on timeout
    task automatic xact(input logic [63:0] a, input logic w, input logic [7:0] s,
                        input logic [63:0] d, output int l, output logic e,
                        output logic [63:0] r);
        mem_req   = 1'b1;
        mem_addr  = a;
        mem_wen   = w;
        mem_strb  = s;
        mem_wdata = d;
        l = 0;
        do begin
            @(posedge g_clk); #1;
            l++;
        end while (!mem_gnt && l < 30);
        if (!mem_gnt) l = -1;
        e = mem_err;
        r = mem_rdata;
        mem_req = 1'b0;
        @(posedge g_clk); #1;
    endtask

    initial begin
        g_resetn  = 1'b0;
        stall_en  = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_strb  = '0;
        mem_wdata = '0;
        for (int i = 0; i < 8; i++) hist[i] = 0;

        repeat (3) @(posedge g_clk);
        #1;
        check("rst_gnt",   64'(mem_gnt),   64'd0);
        check("rst_err",   64'(mem_err),   64'd0);
        check("rst_rdata", mem_rdata,      64'd0);
        check("rst_proto", 64'(proto_err), 64'd0);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;

        // full write then read-back, no stalls
        xact(64'h10, 1'b1, 8'hFF, 64'h1122334455667788, lat, err, rd);
        check("wr_lat", 64'(lat), 64'd2);
        check("wr_err", 64'(err), 64'd0);
        check("wr_rd0", rd,       64'd0);
        xact(64'h10, 1'b0, 8'h00, 64'h0, lat, err, rd);
        check("rd_lat",  64'(lat), 64'd2);
        check("rd_err",  64'(err), 64'd0);
        check("rd_data", rd,       64'h1122334455667788);

        // partial strobe
        xact(64'h10, 1'b1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, lat, err, rd);
        check("pstrb_err", 64'(err), 64'd0);
        xact(64'h10, 1'b0, 8'h00, 64'h0, lat, err, rd);
        check("pstrb_data", rd, 64'h1122_3344_FFFF_FFFF);

        // error window, in range
        xact(64'h1008, 1'b0, 8'h00, 64'h0, lat, err, rd);
        check("errwin_rd_lat", 64'(lat), 64'd2);
        check("errwin_rd_err", 64'(err), 64'd1);
        check("errwin_rd_dat", rd,       64'd0);
        xact(64'h1008, 1'b1, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, lat, err, rd);
        check("errwin_wr_err", 64'(err), 64'd1);
        check("errwin_wr_rd0", rd,       64'd0);

        // out of range; 0x2010 aliases the index of 0x10 and must not write it
        xact(64'h2000, 1'b0, 8'h00, 64'h0, lat, err, rd);
        check("oor_rd_err", 64'(err), 64'd1);
        check("oor_rd_dat", rd,       64'd0);
        xact(64'h2010, 1'b1, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE, lat, err, rd);
        check("oor_wr_err", 64'(err), 64'd1);
        xact(64'h10, 1'b0, 8'h00, 64'h0, lat, err, rd);
        check("oor_no_write", rd, 64'h1122_3344_FFFF_FFFF);

        // word at 0x20 keeps this value through the reset test below
        xact(64'h20, 1'b1, 8'hFF, 64'hA5A5_0000_1234_5678, lat, err, rd);
        check("wr20_err", 64'(err), 64'd0);

        // random stalls
        stall_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                xact(64'h10, 1'b0, 8'h00, 64'h0, lat, err, rd);
                check("stall_rd_data", rd, 64'h1122_3344_FFFF_FFFF);
            end else begin
                xact(64'h400 + 64'(8 * $urandom_range(0, 63)), 1'b1, 8'hFF,
                     {$urandom, $urandom}, lat, err, rd);
                check("stall_wr_err", 64'(err), 64'd0);
            end
            check("stall_lat_range", 64'(lat >= 2 && lat <= 5), 64'd1);
            if (lat >= 0 && lat < 8) hist[lat]++;
        end
        check("stall0_seen", 64'(hist[2] > 0), 64'd1);
        check("stall1_seen", 64'(hist[3] > 0), 64'd1);
        check("stall2_seen", 64'(hist[4] > 0), 64'd1);
        check("stall3_seen", 64'(hist[5] > 0), 64'd1);
        stall_en = 1'b0;

        // protocol violation: request dropped in WAIT
        mem_req  = 1'b1;
        mem_addr = 64'h18;
        mem_wen  = 1'b0;
        @(posedge g_clk); #1;
        mem_req = 1'b0;
        @(posedge g_clk); #1;
        check("drop_gnt",   64'(mem_gnt),   64'd0);
        check("drop_proto", 64'(proto_err), 64'd1);
        saw_gnt = 1'b0;
        repeat (4) begin
            @(posedge g_clk); #1;
            saw_gnt = saw_gnt | mem_gnt;
        end
        check("drop_no_gnt", 64'(saw_gnt), 64'd0);

        // protocol violation: address changed in WAIT
        mem_req  = 1'b1;
        mem_addr = 64'h18;
        @(posedge g_clk); #1;
        mem_addr = 64'h20;
        @(posedge g_clk); #1;
        mem_req = 1'b0;
        saw_gnt = mem_gnt;
        repeat (4) begin
            @(posedge g_clk); #1;
            saw_gnt = saw_gnt | mem_gnt;
        end
        check("addr_chg_no_gnt", 64'(saw_gnt),   64'd0);
        check("addr_chg_proto",  64'(proto_err), 64'd1);

        xact(64'h10, 1'b0, 8'h00, 64'h0, lat, err, rd);
        check("post_viol_lat",   64'(lat),       64'd2);
        check("post_viol_data",  rd,             64'h1122_3344_FFFF_FFFF);
        check("proto_sticky",    64'(proto_err), 64'd1);

        // async reset during WAIT of a write to 0x20
        mem_req   = 1'b1;
        mem_addr  = 64'h20;
        mem_wen   = 1'b1;
        mem_strb  = 8'hFF;
        mem_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
        @(posedge g_clk); #2;
        g_resetn = 1'b0;
        #1;
        check("arst_gnt",   64'(mem_gnt),   64'd0);
        check("arst_err",   64'(mem_err),   64'd0);
        check("arst_rdata", mem_rdata,      64'd0);
        check("arst_proto", 64'(proto_err), 64'd0);
        #1;
        g_resetn = 1'b1;
        mem_req  = 1'b0;
        mem_wen  = 1'b0;
        @(posedge g_clk); #1;
        xact(64'h20, 1'b0, 8'h00, 64'h0, lat, err, rd);
        check("arst_rd_lat",  64'(lat), 64'd2);
        check("arst_old_val", rd,       64'hA5A5_0000_1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire
